spsram_wb_arbiter: RTL and testbench
====================================

# spsram_wb_arbiter

Two-port Wishbone-classic front end for the single-port SRAM macro. Arbitrates between the instruction master (m0) and the data master (m1), sequences one access at a time into the memory port, and returns acknowledge and read data. The downstream memory has byte-mask writes and a registered read with 1-cycle latency. This block sits directly between the core's two bus ports and the SRAM, so the two masters can share one physical memory.

## Interface

**Parameters**
- `AWIDTH`, default 32: address width of both Wishbone ports and of the memory port.

**Clock and reset**
- One clock; reset is synchronous and active-low.
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rstz`, in, 1: synchronous reset, active-low.

**Master ports** (x = 0 or 1; m0 = instruction, m1 = data)
- `mx_wb_adr_i`, in, AWIDTH: byte address; passed through unmodified.
- `mx_wb_dat_i`, in, 32: write data.
- `mx_wb_dat_o`, out, 32: read data; continuous copy of `mem_rdata`, valid only while `mx_wb_ack_o`=1.
- `mx_wb_sel_i`, in, 4: byte select.
- `mx_wb_we_i`, in, 1: 1 = write.
- `mx_wb_stb_i`, in, 1: strobe.
- `mx_wb_cyc_i`, in, 1: cycle valid.
- `mx_wb_ack_o`, out, 1: transfer acknowledge.

**Memory port**
- `mem_addr`, out, AWIDTH: address of the granted master.
- `mem_wdata`, out, 32: write data of the granted master.
- `mem_rdata`, in, 32: registered read data, valid the cycle after a read issue.
- `mem_en`, out, 1: access enable.
- `mem_wr_en`, out, 1: write enable.
- `mem_mask`, out, 4: byte mask.

## Operation

**Request and grant**
- A master requests when `cyc & stb` = 1.
- `grant` is a registered 1-bit master index.
- `last` is a registered 1-bit value: the index of the most recently granted master.

**States:** IDLE, ACCESS, ACK. State, `grant` and `last` are all registered.
- **IDLE**
  - No request: stay in IDLE.
  - One master requesting: `grant` = that master; go to ACCESS.
  - Both requesting: `grant` = `!last` (round-robin); go to ACCESS.
  - `last` is updated to `grant` on the transition.
- **ACCESS**
  - Memory outputs are driven combinationally from the granted master's inputs.
  - `mem_en` = granted master's `cyc & stb`; `mem_wr_en` = its `we`; `mem_mask` = its `sel`; `mem_addr` and `mem_wdata` = its adr and dat.
  - If the granted `cyc & stb` = 1: go to ACK.
  - Otherwise (abort): `mem_en` = 0, go to IDLE, no ack.
- **ACK**
  - Granted master's `ack_o` = granted `cyc & stb` (no ack to a master that dropped cyc; a write is already committed).
  - Other master's `ack_o` = 0.
  - Next state is always IDLE.
- **Outside ACCESS:** `mem_en` = 0, `mem_wr_en` = 0, `mem_mask` = 0; `mem_addr` and `mem_wdata` are don't-care.

**Rules**
- A non-granted master is never acked and never reaches memory.
- Re-arbitration happens per transfer; there is no bus lock.
- A master holding `stb` high after its ack is treated as a new request in IDLE and competes normally.
- A read with `sel` = 0 still issues `mem_en` and acks.
- A write with `sel` = 0 issues `mem_en`/`mem_wr_en` with mask 0 (no byte changes) and acks.

**Reset (`rstz` = 0 at a rising edge)**
- State = IDLE, `last` = 1 (so m0 wins the first tie), `grant` = 0.
- Both acks 0 and `mem_en` 0 from the next cycle.
- Reset during ACCESS or ACK discards the transfer with no ack. A write issued in the ACCESS cycle itself is committed by the memory.

## Timing

- **Latency:** request seen in IDLE at cycle T → memory access in T+1 → ack in T+2. Read data is on `mx_wb_dat_o` during T+2.
- **Throughput:** one transfer per 3 cycles, regardless of master.
- **Contention:** under continuous requests from both masters, grants alternate m0, m1, m0, …; each master is acked every 6 cycles.
- **Combinational paths:** `mem_*` outputs depend on master inputs only in ACCESS. `ack_o` depends on `cyc & stb` only in ACK.

## Test plan

- **Single read:** preload word 0x10 = 0xDEADBEEF; m0 reads addr 0x40 → `mem_en` in T+1 with `mem_addr` = 0x40, `mem_wr_en` = 0; `m0_ack_o` in T+2 with dat = 0xDEADBEEF; `m1_ack_o` stays 0.
- **Masked write then read:** m1 writes 0xAABBCCDD, sel = 4'b0101 to 0x8 over 0x11111111 → ack at T+2; a subsequent read returns 0x11BB11DD.
- **Contention:** first request after reset has both masters asserting continuously → grant order m0, m1, m0, m1; ack pulses 3 cycles apart, alternating; never both acks high.
- **Abort:** m1 drops `cyc` in ACCESS → `mem_en` = 0 that cycle, no ack, IDLE next cycle; a pending m0 is then granted.
- **Reset mid-operation:** `rstz` = 0 in the ACCESS cycle of an m0 read → no ack; next request is served normally, and on a tie after reset m0 is granted first.
- **Held strobe:** m0 keeps `stb` high across 3 reads of different addresses → 3 acks at cycles T+2, T+5, T+8 with correct data each time.

Source files
------------

// File: rtl/spsram_wb_arbiter.sv
// spsram_wb_arbiter
// Two-port Wishbone-classic front end for a single-port SRAM macro. The
// instruction master (m0) and the data master (m1) are arbitrated round-robin,
// one transfer at a time. Each transfer takes IDLE -> ACCESS -> ACK, which gives
// one transfer every three cycles.
//
// Ports
//   clk, rstz          : clock and synchronous active-low reset
//   m0_wb_* / m1_wb_*  : Wishbone-classic slave ports (adr/dat/sel/we/stb/cyc in;
//                        dat_o/ack_o out). dat_o is a direct copy of mem_rdata.
//   mem_*              : SRAM port. It has a byte mask and a registered read
//                        with one cycle of latency.
module spsram_wb_arbiter #(
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstz,

    input  logic [AWIDTH-1:0] m0_wb_adr_i,
    input  logic [31:0]       m0_wb_dat_i,
    output logic [31:0]       m0_wb_dat_o,
    input  logic [3:0]        m0_wb_sel_i,
    input  logic              m0_wb_we_i,
    input  logic              m0_wb_stb_i,
    input  logic              m0_wb_cyc_i,
    output logic              m0_wb_ack_o,

    input  logic [AWIDTH-1:0] m1_wb_adr_i,
    input  logic [31:0]       m1_wb_dat_i,
    output logic [31:0]       m1_wb_dat_o,
    input  logic [3:0]        m1_wb_sel_i,
    input  logic              m1_wb_we_i,
    input  logic              m1_wb_stb_i,
    input  logic              m1_wb_cyc_i,
    output logic              m1_wb_ack_o,

    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [3:0]        mem_mask
);

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned SWIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;

    logic   req0_c, req1_c, req_g_c;

    // Request qualification per master, plus the request of the granted master.
    assign req0_c  = m0_wb_cyc_i & m0_wb_stb_i;
    assign req1_c  = m1_wb_cyc_i & m1_wb_stb_i;
    assign req_g_c = grant_q ? req1_c : req0_c;

    // The SRAM read data goes straight to both masters. It is only meaningful while that master's ack is high.
    assign m0_wb_dat_o = mem_rdata;
    assign m1_wb_dat_o = mem_rdata;

    // State, grant and round-robin history registers.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;    // m0 wins the first tie after reset
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state, arbitration and memory/ack output decode.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mem_en      = 1'b0;
        mem_wr_en   = 1'b0;
        mem_mask    = SWIDTH'(0);
        mem_addr    = AWIDTH'(0);
        mem_wdata   = DWIDTH'(0);
        m0_wb_ack_o = 1'b0;
        m1_wb_ack_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0_c && req1_c) begin
                    // On a tie, the master that was not granted last time wins.
                    grant_d = ~last_q;
                    last_d  = ~last_q;
                    state_d = ST_ACCESS;
                end else if (req0_c) begin
                    grant_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = ST_ACCESS;
                end else if (req1_c) begin
                    grant_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Memory port follows the granted master combinationally; a
                // dropped request here aborts the transfer without an ack.
                mem_en    = req_g_c;
                mem_wr_en = req_g_c & (grant_q ? m1_wb_we_i : m0_wb_we_i);
                mem_mask  = req_g_c ? (grant_q ? m1_wb_sel_i : m0_wb_sel_i) : SWIDTH'(0);
                mem_addr  = grant_q ? m1_wb_adr_i : m0_wb_adr_i;
                mem_wdata = grant_q ? m1_wb_dat_i : m0_wb_dat_i;
                state_d   = req_g_c ? ST_ACK : ST_IDLE;
            end

            ST_ACK: begin
                // No ack goes to a master that dropped its cycle. A write from that master was already committed.
                if (grant_q) begin
                    m1_wb_ack_o = req1_c;
                end else begin
                    m0_wb_ack_o = req0_c;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spsram_wb_arbiter.sv
// Testbench for spsram_wb_arbiter. The bench models the SRAM that the arbiter fronts.
// It checks each transfer against a word-level shadow memory and the arbitration timing rules.
module tb_spsram_wb_arbiter;

    logic        clk;
    logic        rstz;

    logic [31:0] m0_adr, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel;
    logic        m0_we, m0_stb, m0_cyc, m0_ack;
    logic [31:0] m1_adr, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel;
    logic        m1_we, m1_stb, m1_cyc, m1_ack;

    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr_en;
    logic [3:0]  mem_mask;

    int errors = 0;
    int checks = 0;

    spsram_wb_arbiter #(.AWIDTH(32)) dut (
        .clk         (clk),
        .rstz        (rstz),
        .m0_wb_adr_i (m0_adr),
        .m0_wb_dat_i (m0_dat_i),
        .m0_wb_dat_o (m0_dat_o),
        .m0_wb_sel_i (m0_sel),
        .m0_wb_we_i  (m0_we),
        .m0_wb_stb_i (m0_stb),
        .m0_wb_cyc_i (m0_cyc),
        .m0_wb_ack_o (m0_ack),
        .m1_wb_adr_i (m1_adr),
        .m1_wb_dat_i (m1_dat_i),
        .m1_wb_dat_o (m1_dat_o),
        .m1_wb_sel_i (m1_sel),
        .m1_wb_we_i  (m1_we),
        .m1_wb_stb_i (m1_stb),
        .m1_wb_cyc_i (m1_cyc),
        .m1_wb_ack_o (m1_ack),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_en      (mem_en),
        .mem_wr_en   (mem_wr_en),
        .mem_mask    (mem_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    // SRAM model: byte-masked write, registered read with one cycle of latency.
    logic [31:0] sram [256];
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[9:2]];
            end
        end
    end

    // Reference model: one word array that is updated at ack time.
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc = req; m0_stb = req; m0_we = we; m0_adr = adr; m0_dat_i = dat; m0_sel = sel;
        end else begin
            m1_cyc = req; m1_stb = req; m1_we = we; m1_adr = adr; m1_dat_i = dat; m1_sel = sel;
        end
    endtask

    function automatic logic get_ack(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic [31:0] get_dat(input int m);
        return (m == 0) ? m0_dat_o : m1_dat_o;
    endfunction

    // Runs a single transfer on an idle bus. It expects the ack exactly two cycles after the request.
    task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input string tag, output logic [31:0] rd);
        int   lat;
        logic got;
        got = 1'b0;
        lat = 0;
        rd  = 32'h0;
        set_m(m, 1'b1, we, adr, dat, sel);
        for (int k = 1; k <= 10 && !got; k++) begin
            tick();
            settle();
            if (get_ack(m)) begin
                got = 1'b1;
                lat = k;
                rd  = get_dat(m);
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        if (got) begin
            if (we) ref_mem[adr[9:2]] = merge(ref_mem[adr[9:2]], dat, sel);
            else    chk({tag, "_rdata"}, rd, ref_mem[adr[9:2]]);
        end
        tick();
        set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Random-phase per-master transaction state.
    logic        pend [2];
    logic        acked_prev [2];
    int          age [2];
    logic        t_we [2];
    logic [31:0] t_adr [2];
    logic [31:0] t_dat [2];
    logic [3:0]  t_sel [2];
    logic        iss_v, iss_we;
    logic [31:0] iss_addr, iss_wdata;
    logic [3:0]  iss_sel;

    initial begin
        logic [31:0] rd;
        logic        a;

        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        mem_init = 1'b1;
        rstz     = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state
        tick();
        mem_init = 1'b0;
        settle();
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        tick();
        rstz = 1'b1;

        // Preload 0xDEADBEEF at word 0x10, then do a single m0 read.
        xfer(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, "preload", rd);
        set_m(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        settle();
        chk("rd_t0_mem_en", 32'(mem_en), 32'd0);
        tick(); settle();
        chk("rd_t1_mem_en", 32'(mem_en), 32'd1);
        chk("rd_t1_addr", mem_addr, 32'h40);
        chk("rd_t1_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rd_t1_ack", 32'(m0_ack), 32'd0);
        tick(); settle();
        chk("rd_t2_m0_ack", 32'(m0_ack), 32'd1);
        chk("rd_t2_m1_ack", 32'(m1_ack), 32'd0);
        chk("rd_t2_data", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_t2_mem_en", 32'(mem_en), 32'd0);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Masked write followed by a read. Then a sel=0 write, which must not change the word.
        xfer(1, 1'b1, 32'h8, 32'h1111_1111, 4'hF, "mw_fill", rd);
        xfer(1, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, "mw_mask", rd);
        xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, "mw_read", rd);
        chk("mw_value", rd, 32'h11BB_11DD);
        xfer(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, "sel0_write", rd);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, "sel0_read", rd);
        chk("sel0_value", rd, 32'h11BB_11DD);

        // Contention right after reset: both masters request continuously.
        rstz = 1'b0;
        tick(); tick();
        rstz = 1'b1;
        set_m(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            if (k == 12) begin
                set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            settle();
            chk($sformatf("cont_m0_ack_k%0d", k), 32'(m0_ack), 32'(k == 2 || k == 8));
            chk($sformatf("cont_m1_ack_k%0d", k), 32'(m1_ack), 32'(k == 5 || k == 11));
            chk($sformatf("cont_mem_en_k%0d", k), 32'(mem_en), 32'(k == 1 || k == 4 || k == 7 || k == 10));
            if (k == 1 || k == 7) chk("cont_addr_m0", mem_addr, 32'h40);
            if (k == 4 || k == 10) chk("cont_addr_m1", mem_addr, 32'h8);
            if (m0_ack) chk("cont_m0_data", m0_dat_o, ref_mem[8'h10]);
            if (m1_ack) chk("cont_m1_data", m1_dat_o, ref_mem[8'h02]);
        end

        // Abort: m1 drops cyc in ACCESS, and the pending m0 is then served.
        set_m(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            if (k == 1) begin
                set_m(1, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
                set_m(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
            end
            if (k == 5) set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            settle();
            chk($sformatf("abort_mem_en_k%0d", k), 32'(mem_en), 32'(k == 3));
            chk($sformatf("abort_m1_ack_k%0d", k), 32'(m1_ack), 32'd0);
            chk($sformatf("abort_m0_ack_k%0d", k), 32'(m0_ack), 32'(k == 4));
            if (k == 3) chk("abort_addr", mem_addr, 32'h24);
            if (k == 4) chk("abort_data", m0_dat_o, ref_mem[8'h09]);
        end

        // Reset while an m0 read is in ACCESS. After reset, a tie goes to m0 first.
        set_m(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            if (k == 1) rstz = 1'b0;
            if (k == 2) begin
                rstz = 1'b1;
                set_m(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
            end
            if (k == 5) set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            if (k == 8) set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            settle();
            chk($sformatf("rstop_m0_ack_k%0d", k), 32'(m0_ack), 32'(k == 4));
            chk($sformatf("rstop_m1_ack_k%0d", k), 32'(m1_ack), 32'(k == 7));
            chk($sformatf("rstop_mem_en_k%0d", k), 32'(mem_en), 32'(k == 1 || k == 3 || k == 6));
            if (k == 3) chk("rstop_tie_addr", mem_addr, 32'h40);
            if (k == 4) chk("rstop_m0_data", m0_dat_o, ref_mem[8'h10]);
            if (k == 7) chk("rstop_m1_data", m1_dat_o, ref_mem[8'h02]);
        end

        // m0 holds stb high across three reads of different addresses.
        set_m(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) tick();
            if (k == 3) m0_adr = 32'h8;
            if (k == 6) m0_adr = 32'h24;
            if (k == 9) set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            settle();
            chk($sformatf("held_m0_ack_k%0d", k), 32'(m0_ack), 32'(k == 2 || k == 5 || k == 8));
            if (k == 2) chk("held_data0", m0_dat_o, ref_mem[8'h10]);
            if (k == 5) chk("held_data1", m0_dat_o, ref_mem[8'h02]);
            if (k == 8) chk("held_data2", m0_dat_o, ref_mem[8'h09]);
        end

        // Random traffic from both masters, checked against the shadow memory.
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; acked_prev[m] = 1'b0; age[m] = 0;
            t_we[m] = 1'b0; t_adr[m] = 32'h0; t_dat[m] = 32'h0; t_sel[m] = 4'h0;
        end
        iss_v = 1'b0; iss_we = 1'b0; iss_addr = 32'h0; iss_wdata = 32'h0; iss_sel = 4'h0;
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if (pend[m]) age[m]++;
                if (acked_prev[m]) begin
                    pend[m]       = 1'b0;
                    acked_prev[m] = 1'b0;
                    set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end else if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    t_we[m]  = 1'($urandom_range(0, 1));
                    t_adr[m] = 32'($urandom_range(0, 15)) << 2;
                    t_dat[m] = $urandom;
                    t_sel[m] = 4'($urandom);
                    pend[m]  = 1'b1;
                    age[m]   = 0;
                    set_m(m, 1'b1, t_we[m], t_adr[m], t_dat[m], t_sel[m]);
                end
            end
            settle();
            chk("rnd_both_ack", 32'(m0_ack & m1_ack), 32'd0);
            for (int m = 0; m < 2; m++) begin
                a = get_ack(m);
                chk("rnd_ack_unrequested", 32'(a & ~pend[m]), 32'd0);
                if (a && pend[m]) begin
                    chk("rnd_wait", 32'(age[m] >= 2 && age[m] <= 5), 32'd1);
                    chk("rnd_issue_seen", 32'(iss_v), 32'd1);
                    chk("rnd_issue_addr", iss_addr, t_adr[m]);
                    chk("rnd_issue_we", 32'(iss_we), 32'(t_we[m]));
                    chk("rnd_issue_sel", 32'(iss_sel), 32'(t_sel[m]));
                    if (t_we[m]) begin
                        chk("rnd_issue_wdata", iss_wdata, t_dat[m]);
                        ref_mem[t_adr[m][9:2]] = merge(ref_mem[t_adr[m][9:2]], t_dat[m], t_sel[m]);
                    end else begin
                        chk("rnd_rdata", get_dat(m), ref_mem[t_adr[m][9:2]]);
                    end
                    acked_prev[m] = 1'b1;
                end else if (pend[m] && age[m] > 8) begin
                    chk("rnd_timeout_age", 32'(age[m]), 32'd5);
                    pend[m] = 1'b0;
                    set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end
            end
            iss_v     = mem_en;
            iss_we    = mem_wr_en;
            iss_addr  = mem_addr;
            iss_wdata = mem_wdata;
            iss_sel   = mem_mask;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
